// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Input stage for the icebreaker board designs. Turns raw, bouncing,
// asynchronous push-button pins into clean clock-aligned button levels plus
// single-cycle press/release pulses used downstream as step enables.
// Every channel is identical and fully independent of the others.
//
// Parameters:
//   width_p           number of button channels
//   sync_stages_p     synchronizer flop depth per channel (>= 2)
//   debounce_cycles_p consecutive samples the synchronized input must differ
//                     from the debounced level before that level flips (>= 1)
//
// Ports:
//   clk_i                  system clock (12 MHz on board)
//   reset_n_i              asynchronous active-low reset
//   button_async_unsafe_i  raw active-high button pins
//   button_o               debounced, synchronized level (1 = pressed)
//   press_o                one-cycle pulse on a debounced 0->1 transition
//   release_o              one-cycle pulse on a debounced 1->0 transition
// ---------------------------------------------------------------------------
module button_conditioner #(
   parameter int width_p           = 3,
   parameter int sync_stages_p     = 2,
   parameter int debounce_cycles_p = 120000
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] button_async_unsafe_i,
   output logic [width_p-1:0] button_o,
   output logic [width_p-1:0] press_o,
   output logic [width_p-1:0] release_o
);

   localparam int CNT_W = $clog2(debounce_cycles_p + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_cycles_p - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] STABLE  = 1'b0;
   localparam logic [0:0] PENDING = 1'b1;

   // Synchronizer chain for all channels; stage 0 captures the raw pins and
   // the last stage feeds the debouncers. Nothing sits between the stages so
   // each flop gets a full cycle to resolve metastability.
   logic [sync_stages_p-1:0][width_p-1:0] sync_r;
   logic [width_p-1:0]                    sync_s;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[sync_stages_p-2:0], button_async_unsafe_i};
      end
   end

   assign sync_s = sync_r[sync_stages_p-1];

   for (genvar i = 0; i < width_p; i++) begin : g_chan
      logic [0:0]       state_r;
      logic [CNT_W-1:0] cnt_r;
      logic             lvl_r;
      logic             press_r;
      logic             release_r;

      // Debouncer: the level only flips once the synchronized input has
      // disagreed with it for debounce_cycles_p samples in a row. Any sample
      // that agrees again throws the pending change away and clears the
      // counter. The pulses are registered alongside the level so they line
      // up exactly with the cycle in which button_o shows its new value.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            state_r   <= STABLE;
            cnt_r     <= '0;
            lvl_r     <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
               STABLE: begin
                  if (sync_s[i] != lvl_r) begin
                     // A one-sample threshold has nothing to count, so the
                     // level follows the synchronizer directly.
                     if (debounce_cycles_p == 1) begin
                        lvl_r     <= sync_s[i];
                        press_r   <= sync_s[i];
                        release_r <= ~sync_s[i];
                     end else begin
                        cnt_r   <= CNT_ONE;
                        state_r <= PENDING;
                     end
                  end
               end
               PENDING: begin
                  if (sync_s[i] == lvl_r) begin
                     cnt_r   <= '0;
                     state_r <= STABLE;
                  end else if (cnt_r == CNT_LAST) begin
                     lvl_r     <= sync_s[i];
                     press_r   <= sync_s[i];
                     release_r <= ~sync_s[i];
                     cnt_r     <= '0;
                     state_r   <= STABLE;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
               default: begin
                  cnt_r   <= '0;
                  state_r <= STABLE;
               end
            endcase
         end
      end

      assign button_o[i]  = lvl_r;
      assign press_o[i]   = press_r;
      assign release_o[i] = release_r;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Self-checking bench for button_conditioner with width_p=3,
// sync_stages_p=2, debounce_cycles_p=4. A reference model works from the
// history of pin values captured since reset: the level flips when the last
// debounce_cycles_p samples seen by the debouncer all disagree with it.
// Expected outputs are queued at each rising edge and compared on the
// following falling edge. Per-test pulse tallies are checked against the
// fixed counts each scenario must produce.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

   localparam int WIDTH    = 3;
   localparam int SYNC     = 2;
   localparam int DEBOUNCE = 4;

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] pins;
   logic [WIDTH-1:0] button;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] release_p;

   int checks;
   int failures;

   logic [WIDTH-1:0]       hist[$];
   logic [3*WIDTH-1:0]     exp_q[$];
   logic [WIDTH-1:0]       model_lvl;
   logic [WIDTH-1:0]       model_press;
   logic [WIDTH-1:0]       model_release;
   logic [3*WIDTH-1:0]     exp_word;
   logic                   all_differ;
   int                     last_idx;

   int press_cnt[WIDTH];
   int release_cnt[WIDTH];
   int press_all_cnt;

   button_conditioner #(
      .width_p(WIDTH),
      .sync_stages_p(SYNC),
      .debounce_cycles_p(DEBOUNCE)
   ) dut (
      .clk_i(clk),
      .reset_n_i(reset_n),
      .button_async_unsafe_i(pins),
      .button_o(button),
      .press_o(press),
      .release_o(release_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive pins and reset, then hold them for the given number of rising
   // edges; inputs change 2 time units after an edge, well clear of it.
   task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic rst_n,
                                input int cycles);
      pins    = p;
      reset_n = rst_n;
      repeat (cycles) @(posedge clk);
      #2;
   endtask

   task automatic clearTallies();
      for (int i = 0; i < WIDTH; i++) begin
         press_cnt[i]   = 0;
         release_cnt[i] = 0;
      end
      press_all_cnt = 0;
   endtask

   // Value of channel ch that the debouncer sees at capture edge k: the pin
   // captured SYNC edges earlier, or 0 (reset value) before that.
   function automatic logic sampleSeen(input int k, input int ch);
      if (k - SYNC < 0) return 1'b0;
      return hist[k-SYNC][ch];
   endfunction

   // Reference model, advanced on every rising edge.
   always @(posedge clk) begin
      model_press   = '0;
      model_release = '0;
      if (!reset_n) begin
         hist.delete();
         model_lvl = '0;
      end else begin
         hist.push_back(pins);
         last_idx = hist.size() - 1;
         for (int ch = 0; ch < WIDTH; ch++) begin
            all_differ = 1'b1;
            for (int j = 0; j < DEBOUNCE; j++) begin
               if (sampleSeen(last_idx - j, ch) == model_lvl[ch])
                  all_differ = 1'b0;
            end
            if (all_differ) begin
               model_lvl[ch]     = ~model_lvl[ch];
               model_press[ch]   = model_lvl[ch];
               model_release[ch] = ~model_lvl[ch];
            end
         end
      end
      exp_q.push_back({model_lvl, model_press, model_release});
   end

   // Output monitor: pops the expectation for the cycle just clocked.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_word = exp_q.pop_front();
         if (!reset_n) exp_word = '0;
         checkOutput("button_o",  32'(button),    32'(exp_word[3*WIDTH-1:2*WIDTH]));
         checkOutput("press_o",   32'(press),     32'(exp_word[2*WIDTH-1:WIDTH]));
         checkOutput("release_o", 32'(release_p), 32'(exp_word[WIDTH-1:0]));
         if (reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
               if (press[i])     press_cnt[i]++;
               if (release_p[i]) release_cnt[i]++;
            end
            if (press == 3'b111) press_all_cnt++;
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      model_lvl = '0;
      clearTallies();

      $display("[TB] reset");
      applyStimulus(3'b000, 1'b0, 3);
      checkOutput("reset_button", 32'(button), 32'h0);
      applyStimulus(3'b000, 1'b1, 2);

      $display("[TB] test 1: press bit0");
      clearTallies();
      applyStimulus(3'b001, 1'b1, 10);
      checkOutput("t1_button", 32'(button), 32'h1);
      checkOutput("t1_press_cnt", 32'(press_cnt[0]), 32'd1);
      checkOutput("t1_release_cnt", 32'(release_cnt[0]), 32'd0);

      $display("[TB] test 2: release bit0");
      clearTallies();
      applyStimulus(3'b000, 1'b1, 10);
      checkOutput("t2_button", 32'(button), 32'h0);
      checkOutput("t2_release_cnt", 32'(release_cnt[0]), 32'd1);
      checkOutput("t2_press_cnt", 32'(press_cnt[0]), 32'd0);

      $display("[TB] test 3: bounce on bit1");
      clearTallies();
      applyStimulus(3'b010, 1'b1, 3);
      applyStimulus(3'b000, 1'b1, 1);
      applyStimulus(3'b010, 1'b1, 3);
      applyStimulus(3'b000, 1'b1, 8);
      checkOutput("t3_button", 32'(button), 32'h0);
      checkOutput("t3_press_cnt", 32'(press_cnt[1]), 32'd0);
      checkOutput("t3_release_cnt", 32'(release_cnt[1]), 32'd0);

      $display("[TB] test 4: exact threshold on bit2");
      clearTallies();
      applyStimulus(3'b100, 1'b1, 4);
      applyStimulus(3'b000, 1'b1, 12);
      checkOutput("t4_button", 32'(button), 32'h0);
      checkOutput("t4_press_cnt", 32'(press_cnt[2]), 32'd1);
      checkOutput("t4_release_cnt", 32'(release_cnt[2]), 32'd1);

      $display("[TB] test 5: reset while pending");
      clearTallies();
      applyStimulus(3'b001, 1'b1, 4);
      applyStimulus(3'b001, 1'b0, 2);
      checkOutput("t5_in_reset", 32'({button, press, release_p}), 32'h0);
      checkOutput("t5_no_early_press", 32'(press_cnt[0]), 32'd0);
      applyStimulus(3'b001, 1'b1, 10);
      checkOutput("t5_button", 32'(button), 32'h1);
      checkOutput("t5_press_cnt", 32'(press_cnt[0]), 32'd1);

      $display("[TB] test 6: all channels together");
      applyStimulus(3'b000, 1'b1, 10);
      clearTallies();
      applyStimulus(3'b111, 1'b1, 20);
      checkOutput("t6_button", 32'(button), 32'h7);
      checkOutput("t6_press_all", 32'(press_all_cnt), 32'd1);
      for (int i = 0; i < WIDTH; i++)
         checkOutput("t6_press_cnt", 32'(press_cnt[i]), 32'd1);

      applyStimulus(3'b111, 1'b1, 2);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] simulation timed out");
   end

endmodule
